ln_credit_unit: RTL and testbench
=================================

// Module: ln_credit_unit
// PURPOSE
//  Natural-log approximator, the inverse of the exp stage: takes UQ3.6 values
//  (9b, the exp output format) and returns ln(x) in saturated Q1.6 (8b signed).
//  Credit flow control on both sides; sits between the exp/accumulate path and
//  the log-domain normaliser of the attention engine. Non-stalling 2-stage pipe.
// PARAMETERS
//  IN_DEPTH     4  input FIFO entries = credits granted to upstream at reset (>=2)
//  OUT_CREDITS  2  credits held for downstream at reset (1..15)
// PORTS
//  clk           in   1  single clock, all logic posedge
//  rst_n         in   1  asynchronous, active-low reset
//  in_valid      in   1  upstream push, legal only while upstream holds a credit
//  in_data       in   9  x, UQ3.6
//  in_credit     out  1  1-cycle pulse: one input FIFO slot freed
//  out_valid     out  1  1-cycle pulse: out_data valid
//  out_data      out  8  ln(x), Q1.6 two's complement, saturated
//  out_credit    in   1  1-cycle pulse from downstream: one slot freed
//  err_overflow  out  1  sticky: push seen with FIFO full (entry dropped)
// BEHAVIOUR
//  Reset: FIFO empty, pipe empty, credit counter = OUT_CREDITS, all outputs 0.
//  Push: in_valid sampled at posedge, written if not full, else dropped and
//   err_overflow set (cleared only by reset).
//  Pop: combinational in any cycle with FIFO non-empty AND cnt>0; pop reserves a
//   downstream credit (cnt--). out_credit pulse: cnt++. Same cycle: cnt unchanged.
//  in_credit: registered, high the cycle after each pop edge.
//  Pipeline: S1 registered at pop edge (k, f); S2 registered next edge (result).
//   out_valid high the cycle after S2 edge; min latency = 2 edges from accept
//   edge (FIFO empty, cnt>0). Throughput 1/cycle while credits last.
//  Arithmetic: m = MSB position of x (0..8); k = m-6 (signed, -6..2);
//   f = 6 bits below the leading one (x<<(6-m) or x>>(m-6)), Q0.6.
//   y = k*44 + ln1p(f)  (ln2 = 44/64), 11b signed, then saturate to [-128,127].
//   x=0: y forced to -128 (0x80), no error flag.
//  Boundaries: cnt never wraps (pop gated at 0; out_credit with cnt==OUT_CREDITS
//   is a protocol violation, saturate). FIFO full+pop+push same cycle: accepted.
//  Reset mid-operation: in-flight data discarded, no in_credit pulses emitted;
//   neighbours share rst_n and re-initialise their credit counts.
// CONFIGURATION
//  LN_QUAD_CORR_EN defined: ln1p(f) = f - ((f*f)>>8) (f^2/4, truncated).
//  Undefined: ln1p(f) = f (linear). Latency/interface identical either way.
// STRUCTURE
//  Package ln_pkg: IN_W=9, OUT_W=8, FRAC=6, LN2_Q6=44, OUT_MIN=-128, OUT_MAX=127,
//   typedefs for uq3_6_t, q1_6_t, k_t (signed 4b).
//  Sub-module ln_lod9: 9b leading-one detector -> {zero, m[3:0]}.
//  FIFO and credit counter inline.
// TESTING
//  x=64 (1.0) -> 0x00; x=128 (2.0) -> 0x2C (44); x=32 (0.5) -> 0xD4 (-44).
//  x=0 -> 0x80; x=511 -> 0x7F (88+63 saturates); x=1 -> 0x80 (k=-6 saturates).
//  x=96 (1.5): linear -> 0x20 (32); with LN_QUAD_CORR_EN -> 0x1C (28).
//  OUT_CREDITS=2, push 4, no out_credit -> exactly 2 outputs, 2 in_credit
//   pulses; one out_credit -> 3rd output 2 edges later.
//  IN_DEPTH=4, cnt=0, push 5 -> err_overflow=1, 5th value never emerges.
//  Assert rst_n with 3 entries queued -> outputs 0 immediately, no output after.

Source files
------------

// File: rtl/ln_pkg.sv
// rtl/ln_pkg.sv - shared widths, constants, types and saturation helper for the ln credit unit
package ln_pkg;

    localparam int IN_W    = 9;
    localparam int OUT_W   = 8;
    localparam int FRAC    = 6;
    localparam int LN2_Q6  = 44;
    localparam int OUT_MIN = -128;
    localparam int OUT_MAX = 127;

    typedef logic [IN_W-1:0]         uq3_6_t;
    typedef logic signed [OUT_W-1:0] q1_6_t;
    typedef logic signed [3:0]       k_t;

    // Clamp the wide log sum into the Q1.6 output range.
    function automatic q1_6_t ln_saturate(input logic signed [10:0] y);
        if (y < 11'(OUT_MIN)) begin
            return q1_6_t'(OUT_MIN);
        end else if (y > 11'(OUT_MAX)) begin
            return q1_6_t'(OUT_MAX);
        end else begin
            return q1_6_t'(y[OUT_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/ln_lod9.sv
// rtl/ln_lod9.sv - 9-bit leading-one detector
//
// Ports:
//   x     in   9  value to scan
//   zero  out  1  x has no bits set
//   m     out  4  index of the most significant set bit (0 when x is zero)
module ln_lod9 import ln_pkg::*; (
    input  logic [IN_W-1:0] x,
    output logic            zero,
    output logic [3:0]      m
);

    always_comb begin
        m = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (x[i]) begin
                m = 4'(i);
            end
        end
    end

    assign zero = (x == '0);

endmodule

// File: rtl/ln_credit_unit.sv
// rtl/ln_credit_unit.sv - credit-flow-controlled natural-log approximator, UQ3.6 in, Q1.6 out
//
// Optional feature macro: LN_QUAD_CORR_EN (adds the -f^2/4 term to ln(1+f)).
//
// Ports:
//   clk           in   1  clock
//   rst_n         in   1  asynchronous active-low reset
//   in_valid      in   1  upstream push (upstream must hold a credit)
//   in_data       in   9  x, UQ3.6
//   in_credit     out  1  pulse: one input FIFO slot freed
//   out_valid     out  1  pulse: out_data valid
//   out_data      out  8  ln(x), Q1.6 saturated
//   out_credit    in   1  pulse from downstream: one slot freed
//   err_overflow  out  1  sticky: push dropped because FIFO was full
module ln_credit_unit import ln_pkg::*; #(
    parameter int IN_DEPTH    = 4,
    parameter int OUT_CREDITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_credit,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_credit,
    output logic             err_overflow
);

    localparam int PW = $clog2(IN_DEPTH);
    localparam int CW = $clog2(IN_DEPTH + 1);

    uq3_6_t          mem [IN_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      cnt;

    logic            full;
    logic            pop;
    logic            accept;

    uq3_6_t          head;
    logic            head_zero;
    logic [3:0]      head_m;
    logic [FRAC-1:0] head_f;

    logic            s1_valid;
    logic            s1_zero;
    k_t              s1_k;
    logic [FRAC-1:0] s1_f;
    logic [FRAC-1:0] ln1p;
    logic signed [10:0] y;
    q1_6_t           result;

    assign full   = (count == CW'(IN_DEPTH));
    assign pop    = (count != '0) && (cnt != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept = in_valid && (!full || pop);

    assign head = mem[rd_ptr];

    ln_lod9 u_lod (
        .x    (head),
        .zero (head_zero),
        .m    (head_m)
    );

    // Normalise so the leading one sits at bit 6; the six bits below it are f.
    assign head_f = (head_m >= 4'd6) ? FRAC'(head >> (head_m - 4'd6))
                                     : FRAC'(head << (4'd6 - head_m));

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
            in_credit    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PW'(IN_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(IN_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count        <= count + CW'(accept) - CW'(pop);
            err_overflow <= err_overflow | (in_valid && !accept);
            in_credit    <= pop;
        end
    end

    // Downstream credit counter; a surplus credit return is absorbed at the cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'(OUT_CREDITS);
        end else begin
            case ({pop, out_credit})
                2'b10:   cnt <= cnt - 4'd1;
                2'b01:   if (cnt != 4'(OUT_CREDITS)) cnt <= cnt + 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_k     <= '0;
            s1_f     <= '0;
        end else begin
            s1_valid <= pop;
            if (pop) begin
                s1_zero <= head_zero;
                s1_k    <= k_t'(head_m - 4'd6);
                s1_f    <= head_f;
            end
        end
    end

`ifdef LN_QUAD_CORR_EN
    logic [2*FRAC-1:0] f_sq;
    assign f_sq = {{FRAC{1'b0}}, s1_f} * {{FRAC{1'b0}}, s1_f};
    assign ln1p = s1_f - FRAC'(f_sq >> 8);
`else
    assign ln1p = s1_f;
`endif

    assign y      = 11'(s1_k) * 11'(LN2_Q6) + $signed({5'b0, ln1p});
    assign result = s1_zero ? q1_6_t'(OUT_MIN) : ln_saturate(y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid;
            out_data  <= s1_valid ? result : '0;
        end
    end

endmodule

// File: tb/tb_ln_credit_unit.sv
// tb/tb_ln_credit_unit.sv - self-checking bench for ln_credit_unit
module tb_ln_credit_unit;

    localparam int IN_DEPTH    = 4;
    localparam int OUT_CREDITS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] in_data = '0;
    logic       out_credit = 1'b0;
    logic       in_credit;
    logic       out_valid;
    logic [7:0] out_data;
    logic       err_overflow;

    int passed = 0;
    int total  = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         credit_pulses = 0;
    int         cyc = 0;

    ln_credit_unit #(.IN_DEPTH(IN_DEPTH), .OUT_CREDITS(OUT_CREDITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_credit    (in_credit),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_credit   (out_credit),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (in_credit) credit_pulses++;
    end

    // ln(x) from its definition: x = 2^(m-6) * (1+f), ln = (m-6)*ln2 + ln(1+f).
    function automatic logic [7:0] ln_ref(input int x);
        int m, f, l, y;
        if (x == 0) return 8'h80;
        m = 0;
        for (int i = 0; i < 9; i++) if (x >= (1 << i)) m = i;
        f = ((x * 64) >> m) - 64;
`ifdef LN_QUAD_CORR_EN
        l = f - (f * f) / 256;
`else
        l = f;
`endif
        y = (m - 6) * 44 + l;
        if (y < -128) y = -128;
        if (y > 127) y = 127;
        return 8'(y);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_credit = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        got_q.delete();
        got_cyc.delete();
        credit_pulses = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data); else passed++;
        total++; if (in_credit !== 1'b0) $display("FAIL reset_in_credit got %b want 0", in_credit); else passed++;
        total++; if (err_overflow !== 1'b0) $display("FAIL reset_err_overflow got %b want 0", err_overflow); else passed++;
        do_reset();
    endtask

    task automatic test_vectors();
        int         xs[7];
        logic [7:0] exp[7];
        xs = '{64, 128, 32, 0, 511, 1, 96};
        exp[0] = 8'h00; exp[1] = 8'h2C; exp[2] = 8'hD4; exp[3] = 8'h80;
        exp[4] = 8'h7F; exp[5] = 8'h80;
`ifdef LN_QUAD_CORR_EN
        exp[6] = 8'h1C;
`else
        exp[6] = 8'h20;
`endif
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(xs[i]);
            step();
            in_valid = 1'b0;
            step();
            total++; if (out_valid !== 1'b0) $display("FAIL vec_early x=%0d out_valid got %b want 0", xs[i], out_valid); else passed++;
            step();
            total++; if (out_valid !== 1'b1 || out_data !== exp[i]) $display("FAIL vec x=%0d got valid=%b data=%h want valid=1 data=%h", xs[i], out_valid, out_data, exp[i]); else passed++;
            out_credit = 1'b1;
            step();
            out_credit = 1'b0;
        end
    endtask

    task automatic test_credit_stall();
        logic [8:0] v[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v[i] = 9'($urandom_range(0, 511));
            in_valid = 1'b1;
            in_data  = v[i];
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        total++; if (got_q.size() != 2) $display("FAIL stall_count got %0d want 2", got_q.size()); else passed++;
        total++; if (credit_pulses != 2) $display("FAIL stall_in_credit got %0d want 2", credit_pulses); else passed++;
        if (got_q.size() >= 2) begin
            total++; if (got_q[0] !== ln_ref(v[0])) $display("FAIL stall_d0 got %h want %h", got_q[0], ln_ref(v[0])); else passed++;
            total++; if (got_q[1] !== ln_ref(v[1])) $display("FAIL stall_d1 got %h want %h", got_q[1], ln_ref(v[1])); else passed++;
            total++; if (got_cyc[1] - got_cyc[0] != 1) $display("FAIL back_to_back gap got %0d want 1", got_cyc[1] - got_cyc[0]); else passed++;
        end
        out_credit = 1'b1;
        step();
        out_credit = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL credit_resume_early got %b want 0", out_valid); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_data !== ln_ref(v[2])) $display("FAIL credit_resume got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, ln_ref(v[2])); else passed++;
    endtask

    task automatic test_overflow();
        logic [8:0] v[5];
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 9'($urandom_range(0, 511));
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 5; i++) begin
            v[i] = 9'($urandom_range(0, 511));
            in_valid = 1'b1;
            in_data  = v[i];
            if (i == 4) begin
                total++; if (err_overflow !== 1'b0) $display("FAIL ovf_before got %b want 0", err_overflow); else passed++;
            end
            step();
        end
        in_valid = 1'b0;
        step();
        total++; if (err_overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", err_overflow); else passed++;
        for (int i = 0; i < 5; i++) begin
            out_credit = 1'b1;
            step();
        end
        out_credit = 1'b0;
        repeat (10) step();
        total++; if (got_q.size() != 6) $display("FAIL ovf_count got %0d want 6", got_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > 2 + i) begin
                total++; if (got_q[2 + i] !== ln_ref(v[i])) $display("FAIL ovf_d%0d got %h want %h", i, got_q[2 + i], ln_ref(v[i])); else passed++;
            end
        end
        total++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", err_overflow); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int up_cred = IN_DEPTH;
        int pend = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (in_valid) begin
                exp_q.push_back(ln_ref(int'(in_data)));
            end
            in_valid   = 1'b0;
            out_credit = 1'b0;
            if (up_cred > 0 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = 9'($urandom_range(0, 511));
                up_cred--;
            end
            if (pend > 0 && $urandom_range(0, 1) == 1) begin
                out_credit = 1'b1;
                pend--;
            end
            step();
            if (in_credit) up_cred++;
            if (out_valid) pend++;
        end
        if (in_valid) exp_q.push_back(ln_ref(int'(in_data)));
        in_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            out_credit = (pend > 0);
            if (pend > 0) pend--;
            step();
            if (out_valid) pend++;
        end
        out_credit = 1'b0;
        step();
        total++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_d%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        total++; if (err_overflow !== 1'b0) $display("FAIL rand_ovf got %b want 0", err_overflow); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 9'($urandom_range(1, 511));
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 9'($urandom_range(64, 511));
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        out_credit = 1'b1;
        step();
        out_credit = 1'b0;
        step();
        step();
        total++; if (out_valid !== 1'b1) $display("FAIL mid_inflight got %b want 1", out_valid); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", out_data); else passed++;
        total++; if (in_credit !== 1'b0) $display("FAIL mid_rst_in_credit got %b want 0", in_credit); else passed++;
        repeat (3) step();
        rst_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
        credit_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            out_credit = (c % 3 == 0);
            step();
        end
        out_credit = 1'b0;
        total++; if (got_q.size() != 0) $display("FAIL mid_after_outputs got %0d want 0", got_q.size()); else passed++;
        total++; if (credit_pulses != 0) $display("FAIL mid_after_in_credit got %0d want 0", credit_pulses); else passed++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_credit_stall();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
